// File: rtl/awb_gain_ctrl_if.sv
// ---------------------------------------------------------------------------
// awb_gain_ctrl_if
// Groups the statistics input, frame timing, clamp bounds and the committed
// gain / status outputs of awb_gain_ctrl into one bundle.
//   master : drives awb_en, frame_start, stat_vld, r/g/b_sum, gain_min/max;
//            receives r/g/b_gain, gain_upd, busy, pending, stat_drop
//   slave  : the controller side (directions reversed)
// ---------------------------------------------------------------------------
interface awb_gain_ctrl_if #(
    parameter int SW = 36,
    parameter int GW = 12
);
    logic          awb_en;
    logic          frame_start;
    logic          stat_vld;
    logic [SW-1:0] r_sum;
    logic [SW-1:0] g_sum;
    logic [SW-1:0] b_sum;
    logic [GW-1:0] gain_min;
    logic [GW-1:0] gain_max;
    logic [GW-1:0] r_gain;
    logic [GW-1:0] g_gain;
    logic [GW-1:0] b_gain;
    logic          gain_upd;
    logic          busy;
    logic          pending;
    logic          stat_drop;

    modport master (
        output awb_en, frame_start, stat_vld, r_sum, g_sum, b_sum, gain_min, gain_max,
        input  r_gain, g_gain, b_gain, gain_upd, busy, pending, stat_drop
    );

    modport slave (
        input  awb_en, frame_start, stat_vld, r_sum, g_sum, b_sum, gain_min, gain_max,
        output r_gain, g_gain, b_gain, gain_upd, busy, pending, stat_drop
    );
endinterface

// File: rtl/awb_gain_ctrl.sv
// ---------------------------------------------------------------------------
// awb_gain_ctrl
// Frame-level auto-white-balance gain controller. Captures per-frame channel
// sums, computes grey-world R and B gains with one shared restoring serial
// divider (GW cycles per division, MSB first), clamps them into a shadow
// register and commits the shadow atomically on the next frame_start.
//
// Ports:
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   bus   : awb_gain_ctrl_if.slave (stats in, frame timing, clamp bounds,
//           committed gains and gain_upd / busy / pending / stat_drop)
//
// Build option: define AWB_CTRL_SMOOTH_EN to insert a SMOOTH state that moves
// each shadow gain a quarter of the way from the committed gain toward the
// clamped target and re-clamps it.
// ---------------------------------------------------------------------------
module awb_gain_ctrl #(
    parameter int SW   = 36,
    parameter int GW   = 12,
    parameter int FRAC = 8
) (
    input logic           clk,
    input logic           rstn,
    awb_gain_ctrl_if.slave bus
);

    // Divider datapath wide enough to hold divisor << GW for the overflow test.
    localparam int DW = SW + 1 + GW;
    localparam int CW = $clog2(GW);
    localparam logic [GW-1:0] UNITY_C = GW'(1'b1) << FRAC;
    localparam logic [GW-1:0] SAT_C   = {GW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIV_R  = 3'd1,
        ST_DIV_B  = 3'd2,
        ST_CLAMP  = 3'd3,
        ST_SMOOTH = 3'd4,
        ST_READY  = 3'd5
    } state_t;

    // Dividend is G << FRAC; the divisor doubles R or B because G covers twice the pixels.
    function automatic logic [DW-1:0] dividend_f(input logic [SW-1:0] g);
        return DW'({g, {FRAC{1'b0}}});
    endfunction

    function automatic logic [DW-1:0] divisor_f(input logic [SW-1:0] s);
        return DW'({s, 1'b0});
    endfunction

    // Quotient would not fit in GW bits (or divide by zero): force all-ones.
    function automatic logic sat_f(input logic [SW-1:0] g, input logic [SW-1:0] s);
        logic [DW-1:0] d;
        d = divisor_f(s);
        return (d == {DW{1'b0}}) || (dividend_f(g) >= (d << GW));
    endfunction

    function automatic logic [GW-1:0] clamp_f(input logic [GW-1:0] v,
                                              input logic [GW-1:0] lo,
                                              input logic [GW-1:0] hi);
        logic [GW-1:0] t;
        if (v < lo) begin
            t = lo;
        end else if (v > hi) begin
            t = hi;
        end else begin
            t = v;
        end
        return t;
    endfunction

`ifdef AWB_CTRL_SMOOTH_EN
    // cur + ((tgt - cur) >>> 2); result lies between cur and tgt so it fits GW bits.
    function automatic logic [GW-1:0] smooth_f(input logic [GW-1:0] cur,
                                               input logic [GW-1:0] tgt);
        logic signed [GW+1:0] diff;
        logic signed [GW+1:0] sum;
        diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        sum  = $signed({2'b00, cur}) + (diff >>> 2);
        return sum[GW-1:0];
    endfunction
`endif

    state_t          state_r, next_s;
    logic [CW-1:0]   cnt_r;
    logic [DW-1:0]   rem_r, dsh_r;
    logic [GW-2:0]   quo_r;
    logic            sat_r;
    logic [SW-1:0]   g_cap_r, b_cap_r;
    logic [GW-1:0]   r_q_r, b_q_r;
    logic [GW-1:0]   shadow_r_r, shadow_b_r;
    logic [GW-1:0]   r_gain_r, b_gain_r, g_gain_r;
    logic            gain_upd_r, busy_r, pending_r, stat_drop_r;

    logic            ge_s, last_s, capture_s, commit_s, busy_st_s;
    logic [DW-1:0]   rem_nx_s;
    logic [GW-1:0]   quo_full_s, result_s;

    // Divider step, handshake qualifiers and busy-state decode
    always_comb begin
        ge_s       = (rem_r >= dsh_r);
        rem_nx_s   = ge_s ? (rem_r - dsh_r) : rem_r;
        quo_full_s = {quo_r, ge_s};
        result_s   = sat_r ? SAT_C : quo_full_s;
        last_s     = (cnt_r == CW'(GW - 1));
        capture_s  = bus.awb_en && bus.stat_vld &&
                     ((state_r == ST_IDLE) || (state_r == ST_READY));
        commit_s   = bus.awb_en && bus.frame_start && (state_r == ST_READY);
        busy_st_s  = (state_r == ST_DIV_R) || (state_r == ST_DIV_B) ||
                     (state_r == ST_CLAMP) || (state_r == ST_SMOOTH);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic; disable overrides every state
    always_comb begin
        next_s = state_r;
        if (!bus.awb_en) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) next_s = ST_DIV_R;
                    else           next_s = ST_IDLE;
                end
                ST_DIV_R: begin
                    if (last_s) next_s = ST_DIV_B;
                    else        next_s = ST_DIV_R;
                end
                ST_DIV_B: begin
                    if (last_s) next_s = ST_CLAMP;
                    else        next_s = ST_DIV_B;
                end
`ifdef AWB_CTRL_SMOOTH_EN
                ST_CLAMP:  next_s = ST_SMOOTH;
`else
                ST_CLAMP:  next_s = ST_READY;
`endif
                ST_SMOOTH: next_s = ST_READY;
                ST_READY: begin
                    // New stats win over an idle return even when committing this cycle.
                    if (capture_s)            next_s = ST_DIV_R;
                    else if (bus.frame_start) next_s = ST_IDLE;
                    else                      next_s = ST_READY;
                end
                default: next_s = ST_IDLE;
            endcase
        end
    end

    // Status outputs registered from the next-state decode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r      <= 1'b0;
            pending_r   <= 1'b0;
            stat_drop_r <= 1'b0;
            gain_upd_r  <= 1'b0;
        end else begin
            busy_r      <= (next_s == ST_DIV_R) || (next_s == ST_DIV_B) ||
                           (next_s == ST_CLAMP) || (next_s == ST_SMOOTH);
            pending_r   <= (next_s == ST_READY);
            stat_drop_r <= bus.awb_en && bus.stat_vld && busy_st_s;
            gain_upd_r  <= commit_s;
        end
    end

    // Committed gains: forced to unity while disabled, loaded from shadow on commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gain_r <= UNITY_C;
            g_gain_r <= UNITY_C;
            b_gain_r <= UNITY_C;
        end else if (!bus.awb_en) begin
            r_gain_r <= UNITY_C;
            g_gain_r <= UNITY_C;
            b_gain_r <= UNITY_C;
        end else if (commit_s) begin
            r_gain_r <= shadow_r_r;
            g_gain_r <= UNITY_C;
            b_gain_r <= shadow_b_r;
        end
    end

    // Capture registers and shared restoring divider (R pass, then B pass)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g_cap_r <= {SW{1'b0}};
            b_cap_r <= {SW{1'b0}};
            rem_r   <= {DW{1'b0}};
            dsh_r   <= {DW{1'b0}};
            quo_r   <= {(GW-1){1'b0}};
            sat_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            r_q_r   <= {GW{1'b0}};
            b_q_r   <= {GW{1'b0}};
        end else if (capture_s) begin
            // R sum goes straight into the divider; G and B are kept for the B pass.
            g_cap_r <= bus.g_sum;
            b_cap_r <= bus.b_sum;
            rem_r   <= dividend_f(bus.g_sum);
            dsh_r   <= divisor_f(bus.r_sum) << (GW - 1);
            sat_r   <= sat_f(bus.g_sum, bus.r_sum);
            quo_r   <= {(GW-1){1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if ((state_r == ST_DIV_R) || (state_r == ST_DIV_B)) begin
            if (last_s) begin
                quo_r <= {(GW-1){1'b0}};
                cnt_r <= {CW{1'b0}};
                if (state_r == ST_DIV_R) begin
                    r_q_r <= result_s;
                    rem_r <= dividend_f(g_cap_r);
                    dsh_r <= divisor_f(b_cap_r) << (GW - 1);
                    sat_r <= sat_f(g_cap_r, b_cap_r);
                end else begin
                    b_q_r <= result_s;
                end
            end else begin
                rem_r <= rem_nx_s;
                dsh_r <= {1'b0, dsh_r[DW-1:1]};
                quo_r <= quo_full_s[GW-2:0];
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end
    end

    // Shadow gains: clamp (and optionally smooth) the quotients
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_r_r <= UNITY_C;
            shadow_b_r <= UNITY_C;
        end else if (!bus.awb_en) begin
            shadow_r_r <= UNITY_C;
            shadow_b_r <= UNITY_C;
        end else begin
            case (state_r)
                ST_CLAMP: begin
                    shadow_r_r <= clamp_f(r_q_r, bus.gain_min, bus.gain_max);
                    shadow_b_r <= clamp_f(b_q_r, bus.gain_min, bus.gain_max);
                end
`ifdef AWB_CTRL_SMOOTH_EN
                ST_SMOOTH: begin
                    shadow_r_r <= clamp_f(smooth_f(r_gain_r, shadow_r_r), bus.gain_min, bus.gain_max);
                    shadow_b_r <= clamp_f(smooth_f(b_gain_r, shadow_b_r), bus.gain_min, bus.gain_max);
                end
`endif
                default: begin
                    shadow_r_r <= shadow_r_r;
                    shadow_b_r <= shadow_b_r;
                end
            endcase
        end
    end

    assign bus.r_gain    = r_gain_r;
    assign bus.g_gain    = g_gain_r;
    assign bus.b_gain    = b_gain_r;
    assign bus.gain_upd  = gain_upd_r;
    assign bus.busy      = busy_r;
    assign bus.pending   = pending_r;
    assign bus.stat_drop = stat_drop_r;

endmodule

// File: doc/awb_gain_ctrl.md
# awb_gain_ctrl

Frame-level controller for the Bayer auto-white-balance path. Captures per-frame R/G/B channel sums from the statistics stage and computes grey-world R and B gains with a shared serial divider. It clamps (and optionally smooths) the gains and commits them atomically at the next frame start. The committed gains drive the per-pixel gain multiplier, so gains change only on frame boundaries.

## Interface
- SW, 36: width of each channel sum input
- GW, 12: gain width, unsigned fixed point
- FRAC, 8: fractional bits of gain (unity = 1<<FRAC = 256)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- awb_en  in  1  block enable; low forces IDLE and unity gains
- frame_start  in  1  single-cycle pulse at first pixel of each frame
- stat_vld  in  1  single-cycle pulse: r_sum/g_sum/b_sum valid for the completed frame
- r_sum, g_sum, b_sum  in  SW each  channel sums (G sum covers twice the pixel count of R/B)
- gain_min, gain_max  in  GW each  clamp bounds, gain_min ≤ gain_max (static)
- r_gain, g_gain, b_gain  out  GW each  committed gains; reset = 256, 256, 256
- gain_upd  out  1  pulse in cycle new gains first appear; reset 0
- busy  out  1  high in DIV_R/DIV_B/CLAMP/SMOOTH; reset 0
- pending  out  1  high in READY (shadow gains awaiting commit); reset 0
- stat_drop  out  1  pulse when stat_vld is discarded; reset 0

## Operation
- FSM states: IDLE, DIV_R, DIV_B, CLAMP, SMOOTH (macro only), READY.
- IDLE: stat_vld latches sums into capture regs → DIV_R.
- Targets: r_t = (g_sum<<FRAC) / (2·r_sum), b_t = (g_sum<<FRAC) / (2·b_sum); g_gain fixed at unity.
- Divider: single restoring serial divider, one quotient bit per cycle, GW cycles per division, MSB first. DIV_R then DIV_B reuse it.
- Saturation: if dividend ≥ divisor<<GW, or divisor == 0, the quotient is all-ones (2^GW−1).
- CLAMP (1 cycle): shadow = min(max(q, gain_min), gain_max) for R and B.
- READY: holds shadow. On frame_start: r_gain/b_gain ← shadow, gain_upd pulses, → IDLE.
- stat_vld in READY without frame_start: newer stats replace pending, → DIV_R; no drop.
- stat_vld and frame_start together in READY: commit the old shadow, capture new sums, → DIV_R.
- stat_vld while busy: ignored; stat_drop pulses next cycle; computation continues.
- frame_start outside READY: no effect on gains.
- awb_en low (any state): → IDLE next cycle; all gains = 256; shadow discarded; no gain_upd.
- Reset mid-operation: all state and outputs return to reset values asynchronously.

## Timing
- stat_vld at cycle t → DIV_R cycles t+1…t+GW → DIV_B t+GW+1…t+2GW → CLAMP t+2GW+1.
- pending high from t+2GW+2 (GW=12: t+26); add 1 cycle with smoothing.
- frame_start at cycle f in READY: new gains registered, visible and gain_upd high at f+1; pending low at f+1.
- Outputs are all registered; no combinational in→out path.

## Configuration
- AWB_CTRL_SMOOTH_EN defined: adds the SMOOTH state after CLAMP. It computes shadow = cur + ((shadow − cur) >>> 2), signed, using the currently committed gain per channel. The result is re-clamped to [gain_min, gain_max].
- AWB_CTRL_SMOOTH_EN undefined: CLAMP goes directly to READY; the clamped target is committed unfiltered.

## Test plan
- Basic: GW=12, FRAC=8, gain_min=64, gain_max=1023; g=2000, r=500, b=1000, frame_start after pending → r_gain=512, b_gain=256, g_gain=256, one gain_upd pulse; pending at t+26.
- Clamp/saturation: r_sum=0, b=4000, g=2000 → r_gain=1023 (saturated then clamped), b_gain=64.
- Overrun: second stat_vld at t+5 → stat_drop pulse at t+6; result equals the first frame's gains.
- Simultaneous: in READY, frame_start+stat_vld same cycle → old gains committed at f+1, busy high at f+1, new gains after the next frame_start.
- Disable: deassert awb_en during DIV_B → gains 256, busy low next cycle, no gain_upd; re-enable and rerun basic case successfully.
- Smoothing (macro defined): committed r=256, target 512 → committed r_gain=320 after one frame, then 368.
